// File: rtl/scramble_key_scheduler.sv
// Keystream scheduler for the camera-to-VGA pixel scrambler: host seeds in, 12-bit LFSR out.
// Optional seed rotation every ROTATE_FRAMES frames is built when KEY_ROTATE_EN is defined.
module scramble_key_scheduler #(
  parameter int CNT_W         = 16,
  parameter int ROTATE_FRAMES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             vsync,
  input  logic             href,
  input  logic             pix_valid,
  input  logic             key_valid,
  input  logic [11:0]      key_data,
  output logic             key_ready,
  output logic             key_err,
  output logic [11:0]      key_out,
  output logic             seed_load,
  output logic             active,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

  if (ROTATE_FRAMES < 1 || ROTATE_FRAMES > 255) begin : g_bad_rotate_frames
    $error("ROTATE_FRAMES must be within 1..255");
  end

  state_t      state, state_next;
  logic [11:0] lfsr, lfsr_next;
  logic [11:0] seed_reg, seed_next;
  logic [11:0] pending_reg;
  logic        pending_valid;
  logic        vsync_d;
  logic        fs;
  logic        accept, accept_seed, accept_zero;
  logic        load, consume;
  logic        fb;

`ifdef KEY_ROTATE_EN
  localparam logic [7:0] ROT_LIMIT = 8'(ROTATE_FRAMES);
  logic [7:0]  frames_since_load, fsl_next;
`endif

  assign fs          = vsync & ~vsync_d;
  assign key_ready   = ~pending_valid;
  assign accept      = key_valid & ~pending_valid;
  assign accept_seed = accept & (|key_data);
  assign accept_zero = accept & ~(|key_data);
  assign fb          = lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0];

  assign key_out = lfsr;
  assign active  = (state == ACTIVE);

  // A frame start always beats a pixel strobe in the same cycle.
  always_comb begin
    state_next = state;
    lfsr_next  = lfsr;
    seed_next  = seed_reg;
    load       = 1'b0;
    consume    = 1'b0;
`ifdef KEY_ROTATE_EN
    fsl_next   = frames_since_load;
`endif
    if (!enable) begin
      state_next = IDLE;
      lfsr_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          lfsr_next = '0;
          if (pending_valid || accept_seed) state_next = ARMED;
        end
        ARMED: begin
          if (fs) begin
            load       = 1'b1;
            consume    = 1'b1;
            seed_next  = pending_reg;
            lfsr_next  = pending_reg;
            state_next = ACTIVE;
`ifdef KEY_ROTATE_EN
            fsl_next   = 8'd1;
`endif
          end
        end
        ACTIVE: begin
          if (fs) begin
            load = 1'b1;
            if (pending_valid) begin
              consume   = 1'b1;
              seed_next = pending_reg;
              lfsr_next = pending_reg;
`ifdef KEY_ROTATE_EN
              fsl_next  = 8'd1;
`endif
            end else begin
`ifdef KEY_ROTATE_EN
              // Rotation adopts the end-of-frame keystream value; zero would lock the LFSR.
              if (frames_since_load == ROT_LIMIT) begin
                seed_next = (lfsr == 12'h000) ? 12'h001 : lfsr;
                lfsr_next = (lfsr == 12'h000) ? 12'h001 : lfsr;
                fsl_next  = 8'd1;
              end else begin
                lfsr_next = seed_reg;
                fsl_next  = frames_since_load + 8'd1;
              end
`else
              lfsr_next = seed_reg;
`endif
            end
          end else if (pix_valid && href) begin
            lfsr_next = {fb, lfsr[11:1]};
          end
        end
        default: begin
          state_next = IDLE;
          lfsr_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      lfsr          <= '0;
      seed_reg      <= '0;
      pending_reg   <= '0;
      pending_valid <= 1'b0;
      vsync_d       <= 1'b0;
      seed_load     <= 1'b0;
      key_err       <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      state     <= state_next;
      lfsr      <= lfsr_next;
      seed_reg  <= seed_next;
      vsync_d   <= vsync;
      seed_load <= load;
      key_err   <= accept_zero;
      if (load) frame_cnt <= frame_cnt + CNT_W'(1);
      // Consuming and accepting are exclusive: accepting needs the slot already empty.
      if (consume) begin
        pending_valid <= 1'b0;
      end else if (accept_seed) begin
        pending_valid <= 1'b1;
        pending_reg   <= key_data;
      end
    end
  end

`ifdef KEY_ROTATE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frames_since_load <= 8'd0;
    else       frames_since_load <= fsl_next;
  end
`endif

endmodule

// File: tb/tb_scramble_key_scheduler.sv
// Self-checking bench for scramble_key_scheduler: directed scenarios then randomized traffic
// against a frame-level model (seed + pixel count) of the keystream.
module tb_scramble_key_scheduler;

`ifdef KEY_ROTATE_EN
  localparam int RF        = 2;
  localparam bit ROTATE_ON = 1'b1;
`else
  localparam int RF        = 8;
  localparam bit ROTATE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, vsync, href, pix_valid, key_valid;
  logic [11:0] key_data;
  logic        key_ready, key_err, seed_load, active;
  logic [11:0] key_out;
  logic [15:0] frame_cnt;

  int unsigned chk_total = 0;
  int unsigned chk_pass  = 0;
  int unsigned chk_fail  = 0;

  // Reference model: mode, a queue for the one-deep seed slot, and the keystream
  // expressed as "frame seed advanced by N pixels".
  int          m_mode;
  logic [11:0] pend_q[$];
  logic [11:0] m_seed, m_base;
  int          m_steps;
  logic        m_vprev, m_err, m_load;
  logic [15:0] m_cnt;
  int          m_fsl;

  scramble_key_scheduler #(.CNT_W(16), .ROTATE_FRAMES(RF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .vsync(vsync), .href(href),
    .pix_valid(pix_valid), .key_valid(key_valid), .key_data(key_data),
    .key_ready(key_ready), .key_err(key_err), .key_out(key_out),
    .seed_load(seed_load), .active(active), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] lfsr_after(input logic [11:0] s, input int n);
    logic [11:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = {v[11] ^ v[5] ^ v[3] ^ v[0], v[11:1]};
    return v;
  endfunction

  function automatic logic [11:0] model_key();
    return lfsr_after(m_base, m_steps);
  endfunction

  task automatic model_reset();
    m_mode = 0; pend_q.delete(); m_seed = '0; m_base = '0; m_steps = 0;
    m_vprev = 1'b0; m_err = 1'b0; m_load = 1'b0; m_cnt = '0; m_fsl = 0;
  endtask

  task automatic start_frame(input logic [11:0] s);
    m_seed = s; m_base = s; m_steps = 0; m_load = 1'b1; m_cnt = m_cnt + 16'd1;
  endtask

  task automatic model_edge();
    bit fs, had_pend, acc;
    logic [11:0] cur, popped;
    fs       = vsync && !m_vprev;
    had_pend = (pend_q.size() != 0);
    acc      = key_valid && !had_pend;
    cur      = model_key();
    m_err    = acc && (key_data == 12'h000);
    m_load   = 1'b0;
    if (!enable) begin
      m_mode = 0; m_base = '0; m_steps = 0;
    end else if (m_mode == 0) begin
      m_base = '0; m_steps = 0;
      if (had_pend || (acc && key_data != 12'h000)) m_mode = 1;
    end else if (m_mode == 1) begin
      if (fs) begin
        popped = pend_q.pop_front(); start_frame(popped); m_fsl = 1; m_mode = 2;
      end
    end else begin
      if (fs) begin
        if (had_pend) begin
          popped = pend_q.pop_front(); start_frame(popped); m_fsl = 1;
        end else if (ROTATE_ON && m_fsl == RF) begin
          start_frame((cur == 12'h000) ? 12'h001 : cur); m_fsl = 1;
        end else begin
          start_frame(m_seed); m_fsl = m_fsl + 1;
        end
      end else if (pix_valid && href) begin
        m_steps = m_steps + 1;
      end
    end
    if (acc && key_data != 12'h000) pend_q.push_back(key_data);
    m_vprev = vsync;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_total++;
    assert (obs === exp) chk_pass++;
    else begin
      chk_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check({tag, ".key_out"},   32'(key_out),   32'(model_key()));
    check({tag, ".key_ready"}, 32'(key_ready), 32'(pend_q.size() == 0));
    check({tag, ".key_err"},   32'(key_err),   32'(m_err));
    check({tag, ".seed_load"}, 32'(seed_load), 32'(m_load));
    check({tag, ".active"},    32'(active),    32'(m_mode == 2));
    check({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(m_cnt));
  endtask

  task automatic apply_stimulus(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_output(tag);
  endtask

  task automatic quiet_inputs();
    enable = 1'b1; vsync = 1'b0; href = 1'b0; pix_valid = 1'b0;
    key_valid = 1'b0; key_data = '0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    quiet_inputs();
    model_reset();
    #1;
    check_output(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_seed(input logic [11:0] s, input string tag);
    key_valid = 1'b1; key_data = s; apply_stimulus({tag, ".offer"});
    key_valid = 1'b0; apply_stimulus({tag, ".armed"});
    vsync = 1'b1;     apply_stimulus({tag, ".fs"});
    vsync = 1'b0;     apply_stimulus({tag, ".post"});
  endtask

  initial begin
    $display("[TB] start, rotation build=%0d", ROTATE_ON);
    do_reset("reset");
    check("reset.key_out_lit", 32'(key_out), 32'h0);
    check("reset.key_ready_lit", 32'(key_ready), 32'h1);

    // Basic seed load and two pixel advances
    key_valid = 1'b1; key_data = 12'h5A3; apply_stimulus("t1.offer");
    check("t1.ready_drop", 32'(key_ready), 32'h0);
    key_valid = 1'b0; apply_stimulus("t1.armed");
    vsync = 1'b1; apply_stimulus("t1.fs");
    check("t1.seed_load_lit", 32'(seed_load), 32'h1);
    check("t1.seed_lit", 32'(key_out), 32'h5A3);
    check("t1.frame_cnt_lit", 32'(frame_cnt), 32'h1);
    pix_valid = 1'b1; href = 1'b1; apply_stimulus("t1.pix1");
    check("t1.pix1_lit", 32'(key_out), 32'h2D1);
    apply_stimulus("t1.pix2");
    check("t1.pix2_lit", 32'(key_out), 32'h968);
    pix_valid = 1'b0; href = 1'b0; vsync = 1'b0; apply_stimulus("t1.idle");

    // Zero seed rejected in IDLE
    do_reset("t2.reset");
    key_valid = 1'b1; key_data = 12'h000; apply_stimulus("t2.offer0");
    check("t2.err_lit", 32'(key_err), 32'h1);
    check("t2.ready_lit", 32'(key_ready), 32'h1);
    key_valid = 1'b0; apply_stimulus("t2.after");
    check("t2.err_clear_lit", 32'(key_err), 32'h0);
    check("t2.active_lit", 32'(active), 32'h0);
    check("t2.key_lit", 32'(key_out), 32'h0);

    // Mid-frame offer replaces the seed at the next frame start
    load_seed(12'h5A3, "t3.load");
    pix_valid = 1'b1; href = 1'b1; apply_stimulus("t3.pix");
    key_valid = 1'b1; key_data = 12'h0F0; apply_stimulus("t3.offer");
    check("t3.ready_drop_lit", 32'(key_ready), 32'h0);
    key_valid = 1'b0; apply_stimulus("t3.pix2");
    pix_valid = 1'b0; vsync = 1'b1; apply_stimulus("t3.fs");
    check("t3.new_seed_lit", 32'(key_out), 32'h0F0);
    vsync = 1'b0; apply_stimulus("t3.low");
    check("t3.ready_back_lit", 32'(key_ready), 32'h1);
    pix_valid = 1'b1; apply_stimulus("t3.pix3");
    pix_valid = 1'b0; vsync = 1'b1; apply_stimulus("t3.fs2");
    check("t3.reload_lit", 32'(key_out), 32'h0F0);

    // Frame start coincident with a pixel, and pixel with href low
    vsync = 1'b0; pix_valid = 1'b1; href = 1'b1; apply_stimulus("t4.pix");
    vsync = 1'b1; apply_stimulus("t4.fs_pix");
    check("t4.no_adv_lit", 32'(key_out), 32'h0F0);
    vsync = 1'b0; href = 1'b0; apply_stimulus("t4.nohref1");
    apply_stimulus("t4.nohref2");
    check("t4.nohref_lit", 32'(key_out), 32'h0F0);
    pix_valid = 1'b0;

    // Disable with a pending key, then re-enable
    key_valid = 1'b1; key_data = 12'h3C7; apply_stimulus("t5.offer");
    key_valid = 1'b0; enable = 1'b0; apply_stimulus("t5.dis");
    check("t5.key_zero_lit", 32'(key_out), 32'h0);
    apply_stimulus("t5.dis2");
    check("t5.pending_kept_lit", 32'(key_ready), 32'h0);
    enable = 1'b1; apply_stimulus("t5.reen");
    check("t5.armed_lit", 32'(active), 32'h0);
    vsync = 1'b1; apply_stimulus("t5.fs");
    check("t5.seed_lit", 32'(key_out), 32'h3C7);
    check("t5.active_lit", 32'(active), 32'h1);
    vsync = 1'b0; apply_stimulus("t5.low");

    // Reset mid-frame with a key pending loses everything
    key_valid = 1'b1; key_data = 12'h111; apply_stimulus("t6.offer");
    key_valid = 1'b0;
    do_reset("t6.reset");
    check("t6.ready_lit", 32'(key_ready), 32'h1);

`ifdef KEY_ROTATE_EN
    // Rotation every two frames adopts the end-of-frame keystream value
    load_seed(12'h5A3, "t7.load");
    pix_valid = 1'b1; href = 1'b1; apply_stimulus("t7.pix1");
    pix_valid = 1'b0; vsync = 1'b1; apply_stimulus("t7.fs2");
    check("t7.frame2_lit", 32'(key_out), 32'h5A3);
    vsync = 1'b0; pix_valid = 1'b1; apply_stimulus("t7.pix2");
    pix_valid = 1'b0; vsync = 1'b1; apply_stimulus("t7.fs3");
    check("t7.frame3_lit", 32'(key_out), 32'h2D1);
    vsync = 1'b0; href = 1'b0; apply_stimulus("t7.low");
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 700; i++) begin
      enable    = ($urandom_range(0, 31) != 0);
      vsync     = ($urandom_range(0, 11) == 0);
      href      = ($urandom_range(0, 3) != 0);
      pix_valid = ($urandom_range(0, 1) == 1);
      key_valid = ($urandom_range(0, 7) == 0);
      key_data  = ($urandom_range(0, 4) == 0) ? 12'h000 : 12'($urandom);
      apply_stimulus("rnd");
    end

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule

// File: doc/scramble_key_scheduler.md
Name: scramble_key_scheduler

Overview:
- Sequences the 12-bit pixel scrambling keystream LFSR for the camera-to-VGA link.
- Accepts new seeds from the host over a valid/ready handshake.
- Loads the active seed into the LFSR at each frame start (vsync rising edge) and advances the LFSR once per active pixel.
- key_out feeds the pixel XOR stage, so transmitter and receiver stay frame-aligned without a separate reset_c pulse.

Parameters:
- CNT_W, 16, width of frame_cnt.
- ROTATE_FRAMES, 8, frames per seed before automatic rotation (used only with KEY_ROTATE_EN; legal range 1..255).

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  async active-high reset.
- enable  in  1  scheduler enable; low forces IDLE.
- vsync  in  1  frame sync, synchronous to clk, active-high.
- href  in  1  line-active qualifier.
- pix_valid  in  1  one-cycle strobe per pixel.
- key_valid  in  1  host seed offer.
- key_data  in  12  host seed.
- key_ready  out  1  seed slot free.
- key_err  out  1  one-cycle pulse: zero seed rejected.
- key_out  out  12  current LFSR value (keystream).
- seed_load  out  1  one-cycle pulse: LFSR reloaded this cycle.
- active  out  1  state == ACTIVE.
- frame_cnt  out  CNT_W  frames started since reset (wraps).

Behaviour:
- Interface: reset is asynchronous and active-high; clock is clk. All other logic is rising-edge clk.
- Reset values: key_out=0, key_ready=1, key_err=0, seed_load=0, active=0, frame_cnt=0. Internal state: state=IDLE, pending_valid=0, seed_reg=0, vsync_d=0.
- LFSR:
  - fb = l[11]^l[5]^l[3]^l[0].
  - next = {fb, l[11:1]}.
  - key_out is the registered LFSR.
- Frame start: fs = vsync & ~vsync_d, where vsync_d is a 1-cycle delayed vsync.
- Handshake:
  - key_ready = ~pending_valid.
  - Accept on key_valid & key_ready.
  - key_data==0 is not stored; it produces a key_err pulse the next cycle.
  - A non-zero accept sets pending_valid=1 and pending_reg=key_data.
  - key_valid with key_ready=0 is held off; no loss, no error.
- FSM:
  - IDLE: key_out=0. A non-zero accept -> ARMED.
  - ARMED: on fs, seed_reg <= pending_reg, LFSR <= pending_reg, pending_valid cleared, seed_load=1, frame_cnt++ -> ACTIVE.
  - ACTIVE:
    - On pix_valid & href & ~fs, advance the LFSR.
    - On fs with pending_valid, load pending_reg (as in ARMED).
    - On fs without pending_valid, reload seed_reg (or rotate, see Optional Feature). seed_load=1, frame_cnt++.
- Latency:
  - seed_load and the new key_out appear the cycle after the fs cycle.
  - A pixel advance appears the cycle after pix_valid.
  - The first pixel of a frame therefore sees key_out == seed.
- Simultaneous events:
  - fs and pix_valid in the same cycle: fs wins, pixel advance dropped.
  - Accept and fs in the same cycle: the accepted key is not used for this frame; it is consumed at the next fs.
- enable=0:
  - Next cycle state=IDLE and key_out=0.
  - pending_reg and pending_valid are kept.
  - Re-enabling with pending_valid=1 goes IDLE -> ARMED immediately.
- Reset mid-frame: all state is cleared and pending is lost; the host must re-offer a seed.
- frame_cnt wraps to 0 after 2^CNT_W-1.

Optional Feature:
- Macro: KEY_ROTATE_EN.
- Defined:
  - In ACTIVE, at fs with no pending key, when frames_since_load == ROTATE_FRAMES, the new seed is the current key_out.
  - If key_out==0, the new seed is 12'h001.
  - The new seed is written to seed_reg and loaded into the LFSR.
  - frames_since_load counts loaded frames and resets to 1 on any seed load from the host or rotation.
- Undefined: seed_reg is reloaded unchanged every frame, and the rotation counter logic is absent.

Test Plan:
- Reset, offer key 12'h5A3, pulse vsync, issue 2 pix_valid with href=1 -> seed_load pulse; key_out = 12'h5A3, then 12'h2D1, then 12'h968; frame_cnt=1.
- Offer key 12'h000 in IDLE -> key_err pulses once, key_ready stays 1, state remains IDLE, key_out=0.
- In ACTIVE with seed 12'h5A3, offer 12'h0F0 mid-frame, then pulse vsync -> key_ready drops after accept; at frame start key_out=12'h0F0 and key_ready returns to 1. A second vsync with no new offer -> key_out reloads 12'h0F0.
- vsync rising coincident with pix_valid & href -> key_out equals the seed (no advance). pix_valid with href=0 -> no advance.
- Drop enable mid-frame with one pending key, then restore and pulse vsync -> key_out=0 while disabled; on restore, ARMED then ACTIVE with the pending seed loaded.
- KEY_ROTATE_EN, ROTATE_FRAMES=2, seed 12'h5A3, 1 pixel per frame, 3 vsync pulses -> frames 1–2 start at 12'h5A3; frame 3 starts at 12'h2D1 (end-of-frame-2 value).
